fir_mac_sequencer: RTL and testbench

Control-and-datapath block that sits on the opposite side of the FIR tap counter. It accepts one input sample per handshake and shifts it into a K-deep delay line. It then issues `tap_start`/`tap_enable` to the tap counter and consumes `tap_index`/`last_cycle` to run exactly K multiply-accumulate cycles against the coefficient ROM. The filtered result is presented on a valid/ready output port.

---
 rtl/fir_mac_sequencer_if.sv | 40 ++++
 rtl/fir_mac_sequencer.sv | 122 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// =============================================================================
// fir_mac_sequencer_if : sample-in, tap-counter and result-out bundle for the
//                        FIR MAC sequencer.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface fir_mac_sequencer_if #(
    parameter int K  = 8,
    parameter int DW = 16,
    parameter int CW = 16
);
    localparam int AW = DW + CW + $clog2(K);
    localparam int TW = $clog2(K);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_sample;
    logic                 tap_start;
    logic                 tap_enable;
    logic [TW-1:0]        tap_index;
    logic                 last_cycle;
    logic signed [CW-1:0] coef;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;

    // master: the sequencer; slave: sample source, tap counter/ROM and sink
    modport master (
        input  in_valid, in_sample, tap_index, last_cycle, coef, out_ready,
        output in_ready, tap_start, tap_enable, out_valid, out_data
    );

    modport slave (
        output in_valid, in_sample, tap_index, last_cycle, coef, out_ready,
        input  in_ready, tap_start, tap_enable, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// =============================================================================
// fir_mac_sequencer : accepts one sample, shifts the K-deep delay line, then
//                     drives the tap counter through K signed MAC cycles.
// Revision : 1.0
// =============================================================================
`default_nettype none

module fir_mac_sequencer #(
    parameter int K  = 8,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    fir_mac_sequencer_if.master bus
);
    localparam int AW = DW + CW + $clog2(K);
    localparam int PW = DW + CW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] x_q [K];
    logic signed [DW-1:0] x_d [K];
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 in_ready_q, in_ready_d;
    logic                 tap_start_q, tap_start_d;
    logic                 tap_enable_q, tap_enable_d;
    logic                 out_valid_q, out_valid_d;

    logic signed [DW-1:0] w_x_sel;
    logic signed [PW-1:0] w_x_ext;
    logic signed [PW-1:0] w_c_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_ext;

    // Operands widened first so the low PW bits hold the exact signed product.
    always_comb begin
        w_x_sel    = x_q[bus.tap_index];
        w_x_ext    = {{CW{w_x_sel[DW-1]}}, w_x_sel};
        w_c_ext    = {{DW{bus.coef[CW-1]}}, bus.coef};
        w_prod     = w_x_ext * w_c_ext;
        w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d[0] = bus.in_sample;
                    for (int i = 1; i < K; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + w_prod_ext;
                if (bus.last_cycle) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake/control outputs are registered decodes of the next state.
        in_ready_d   = (state_d == S_IDLE);
        tap_start_d  = (state_d == S_LOAD);
        tap_enable_d = (state_d == S_MAC);
        out_valid_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < K; i++) begin
                x_q[i] <= '0;
            end
            acc_q        <= '0;
            in_ready_q   <= 1'b1;
            tap_start_q  <= 1'b0;
            tap_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < K; i++) begin
                x_q[i] <= x_d[i];
            end
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            tap_start_q  <= tap_start_d;
            tap_enable_q <= tap_enable_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.tap_start  = tap_start_q;
    assign bus.tap_enable = tap_enable_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// =============================================================================
// tb_fir_mac_sequencer : drives the sequencer with a tap counter and ROM model,
//                        scoring results against a reference FIR.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_fir_mac_sequencer;
    localparam int K  = 8;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int AW = DW + CW + $clog2(K);
    localparam int TW = $clog2(K);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.K(K), .DW(DW), .CW(CW)) bus ();

    fir_mac_sequencer #(.K(K), .DW(DW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [TW-1:0]        tap_q;
    logic signed [CW-1:0] coef_rom [K];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                tap_q <= '0;
        else if (bus.tap_start)  tap_q <= '0;
        else if (bus.tap_enable) tap_q <= tap_q + TW'(1);
    end

    assign bus.tap_index  = tap_q;
    assign bus.last_cycle = (tap_q == TW'(K-1));
    assign bus.coef       = coef_rom[tap_q];

    int checks = 0;
    int errors = 0;
    logic signed [DW-1:0] hist [K];
    logic signed [AW-1:0] sb [$];

    task automatic model_clear();
        for (int i = 0; i < K; i++) hist[i] = '0;
        sb.delete();
    endtask

    task automatic model_accept(input logic signed [DW-1:0] s);
        longint acc;
        acc = 0;
        for (int i = K-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        for (int i = 0; i < K; i++) acc += longint'(hist[i]) * longint'(coef_rom[i]);
        sb.push_back(acc[AW-1:0]);
    endtask

    task automatic set_coef_ramp();
        for (int i = 0; i < K; i++) coef_rom[i] = CW'(i + 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
    endtask

    task automatic send(input logic signed [DW-1:0] s);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_wait: in_ready never rose (got %b, want 1)", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        @(posedge clk);
        model_accept(s);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.out_valid === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_compare(input string name, output logic signed [AW-1:0] got);
        logic signed [AW-1:0] exp;
        bit ok;
        wait_out_valid(ok);
        got = bus.out_data;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: out_valid timeout (got %b, want 1)", name, bus.out_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected output %0d, want none", name, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: out_data got %0d want %0d", name, got, exp);
            end
        end
    endtask

    task automatic do_sample(input logic signed [DW-1:0] s, input string name,
                             output logic signed [AW-1:0] got);
        bus.out_ready = 1'b1;
        send(s);
        pop_compare(name, got);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.tap_start !== 1'b0 ||
            bus.tap_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/ov/ts/te got %b%b%b%b want 1000",
                     bus.in_ready, bus.out_valid, bus.tap_start, bus.tap_enable);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: out_data got %0d want 0", bus.out_data);
        end
    endtask

    task automatic test_impulse();
        logic signed [AW-1:0] got, want;
        do_reset();
        set_coef_ramp();
        for (int n = 0; n < 9; n++) begin
            do_sample((n == 0) ? 16'sd1 : 16'sd0, "impulse_sb", got);
            want = (n < 8) ? AW'(n + 1) : '0;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL impulse[%0d]: got %0d want %0d", n, got, want);
            end
        end
    endtask

    task automatic test_neg_step();
        logic signed [AW-1:0] got, want;
        do_reset();
        for (int i = 0; i < K; i++) coef_rom[i] = -16'sd1;
        for (int n = 0; n < 10; n++) begin
            do_sample(16'sd100, "negstep_sb", got);
            want = AW'(-100 * ((n + 1 < 8) ? n + 1 : 8));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL negstep[%0d]: got %0d want %0d", n, got, want);
            end
        end
    endtask

    task automatic test_worst();
        logic signed [AW-1:0] got, want;
        logic signed [DW-1:0] mn;
        mn = 16'sh8000;
        do_reset();
        for (int i = 0; i < K; i++) coef_rom[i] = 16'sh8000;
        for (int n = 0; n < 8; n++) do_sample(mn, "worst_sb", got);
        want = AW'(64'sd8589934592);
        checks++;
        if (got !== want || got[AW-1] !== 1'b0) begin
            errors++;
            $display("FAIL worst: got %0d want %0d", got, want);
        end
    endtask

    task automatic test_backpressure();
        logic signed [AW-1:0] got, held;
        do_reset();
        set_coef_ramp();
        bus.out_ready = 1'b0;
        send(16'sd5);
        pop_compare("bp_first", held);
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'sd77;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b data=%0d rdy=%b want ov=1 data=%0d rdy=0",
                         n, bus.out_valid, bus.out_data, bus.in_ready, held);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        model_accept(16'sd77);
        #1 bus.in_valid = 1'b0;
        pop_compare("bp_next", got);
        checks++;
        if (got !== AW'(87)) begin
            errors++;
            $display("FAIL bp_value: got %0d want 87", got);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cycle();
        logic signed [AW-1:0] got;
        int en_cnt, first_ov;
        bit ts_bad, en_bad, ts_seen;
        do_reset();
        set_coef_ramp();
        bus.out_ready = 1'b0;
        send(16'sd2);
        en_cnt = 0; first_ov = -1; ts_bad = 0; en_bad = 0; ts_seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.tap_start === 1'b1) begin
                if (n == 0) ts_seen = 1'b1; else ts_bad = 1'b1;
            end
            if (bus.tap_enable === 1'b1) begin
                en_cnt++;
                if (n < 1 || n > 8) en_bad = 1'b1;
            end
            if (bus.out_valid === 1'b1 && first_ov < 0) first_ov = n;
            if (n < 11) begin @(posedge clk); #1; end
        end
        checks++;
        if (!ts_seen || ts_bad) begin
            errors++;
            $display("FAIL cyc_tap_start: seen=%b extra=%b want seen=1 extra=0", ts_seen, ts_bad);
        end
        checks++;
        if (en_cnt != 8 || en_bad) begin
            errors++;
            $display("FAIL cyc_tap_enable: cycles=%0d misplaced=%b want 8/0", en_cnt, en_bad);
        end
        checks++;
        if (first_ov != 9) begin
            errors++;
            $display("FAIL cyc_out_valid: rose after edge %0d want 9", first_ov);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cyc_rdy_held: in_ready got %b want 0", bus.in_ready);
        end
        pop_compare("cyc_data", got);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cyc_handshake: rdy=%b ov=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [AW-1:0] got;
        bit ok;
        set_coef_ramp();
        bus.out_ready = 1'b1;
        send(16'sd9);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.tap_enable === 1'b1 && bus.tap_index == TW'(4)) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_wait: tap_index 4 not reached (got %0d want 4)", bus.tap_index);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.tap_enable !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: ov=%b te=%b rdy=%b want 0/0/1",
                     bus.out_valid, bus.tap_enable, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        do_sample(16'sd3, "mid_after_sb", got);
        checks++;
        if (got !== AW'(3)) begin
            errors++;
            $display("FAIL mid_after: got %0d want 3", got);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < K; i++) coef_rom[i] = '0;
        model_clear();
        #2;
        test_reset();
        test_impulse();
        test_neg_step();
        test_worst();
        test_backpressure();
        test_cycle();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
